// File: rtl/sched_pkg.sv
// Shared types and sizing helpers for the scheduler pipeline stages.
package sched_pkg;

    localparam int DEF_ID_W        = 64;
    localparam int DEF_BATCH_DEPTH = 16;

    typedef enum logic [1:0] {
        COLLECT  = 2'd0,
        DISPATCH = 2'd1,
        CLEAR    = 2'd2
    } disp_state_t;

    // Count width must hold the value BATCH_DEPTH itself, hence the extra bit.
    function automatic int cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

    localparam int CNT_W = cnt_w(DEF_BATCH_DEPTH);

endpackage

// File: rtl/id_buffer.sv
// Batch storage: one write port, one combinational read port.
module id_buffer #(
    parameter int  DEPTH = 16,
    parameter int  W     = 64,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_idx,
    input  logic [W-1:0]  wr_data,
    input  logic [AW-1:0] rd_idx,
    output logic [W-1:0]  rd_data
);

    // Data storage needs no reset: it is only observed after being written.
    logic [W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_idx] <= wr_data;
    end

    assign rd_data = mem[rd_idx];

endmodule

// File: rtl/batch_dispatcher.sv
// Collects accepted IDs into a batch, closes on size or timeout, streams it
// to the executor, then pulses batch_clear for the upstream filter.
module batch_dispatcher
    import sched_pkg::*;
#(
    parameter int  ID_W           = DEF_ID_W,
    parameter int  BATCH_DEPTH    = DEF_BATCH_DEPTH,
    parameter int  TIMEOUT_CYCLES = 256,
    localparam int CW             = cnt_w(BATCH_DEPTH)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            transaction_accepted,
    input  logic [ID_W-1:0] inserted_programID,
    output logic            collect_ready,
    output logic            dispatch_valid,
    output logic [ID_W-1:0] dispatch_programID,
    output logic            dispatch_last,
    input  logic            dispatch_ready,
    output logic            batch_clear,
    output logic [CW-1:0]   batch_count,
    output logic [15:0]     drop_count
);

    localparam int AW = CW - 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES);

    disp_state_t     state, state_nxt;
    logic [AW-1:0]   rd_ptr;
    logic [TW-1:0]   timer;
    logic [CW-1:0]   cnt_nxt;
    logic [ID_W-1:0] rd_data;
    logic            wr_en, drop, close, handshake;

    assign collect_ready  = (state == COLLECT) && (batch_count < CW'(BATCH_DEPTH));
    assign dispatch_valid = (state == DISPATCH);
    assign batch_clear    = (state == CLEAR);
    assign dispatch_last  = dispatch_valid && ({1'b0, rd_ptr} == batch_count - CW'(1));
    assign dispatch_programID = dispatch_valid ? rd_data : '0;

    assign wr_en     = transaction_accepted && collect_ready;
    assign drop      = transaction_accepted && !collect_ready;
    assign handshake = dispatch_valid && dispatch_ready;
    assign cnt_nxt   = batch_count + CW'(wr_en);

    // Close on the post-write count so a same-cycle accept joins the batch.
    assign close = (state == COLLECT) &&
                   ((cnt_nxt == CW'(BATCH_DEPTH)) ||
                    ((timer == TW'(TIMEOUT_CYCLES - 1)) && (cnt_nxt != '0)));

    always_comb begin
        state_nxt = state;
        case (state)
            COLLECT:  if (close) state_nxt = DISPATCH;
            DISPATCH: if (handshake && dispatch_last) state_nxt = CLEAR;
            CLEAR:    state_nxt = COLLECT;
            default:  state_nxt = COLLECT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= COLLECT;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            batch_count <= '0;
            rd_ptr      <= '0;
            timer       <= '0;
            drop_count  <= '0;
        end else begin
            if (state == CLEAR)  batch_count <= '0;
            else if (wr_en)      batch_count <= cnt_nxt;

            if (state == CLEAR)                   rd_ptr <= '0;
            else if (handshake && !dispatch_last) rd_ptr <= rd_ptr + AW'(1);

            // Timer runs from the first write until the batch leaves COLLECT.
            if (state != COLLECT || close)          timer <= '0;
            else if (batch_count != '0 || wr_en)    timer <= timer + TW'(1);

            if (drop && drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
        end
    end

    id_buffer #(.DEPTH(BATCH_DEPTH), .W(ID_W)) u_buf (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_idx  (batch_count[AW-1:0]),
        .wr_data (inserted_programID),
        .rd_idx  (rd_ptr),
        .rd_data (rd_data)
    );

endmodule

// File: tb/tb_batch_dispatcher.sv
// Scoreboard bench: two instances (default timeout and a short timeout of 8).
module tb_batch_dispatcher;
    import sched_pkg::*;

    localparam int IDW = 64;
    localparam int CW  = 5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                 rst_n;
    logic [1:0]           acc, rdy, cr, dv, dl, bclr;
    logic [1:0][IDW-1:0]  pid, did;
    logic [1:0][CW-1:0]   bcnt;
    logic [1:0][15:0]     drop;

    batch_dispatcher #(.ID_W(IDW), .BATCH_DEPTH(16), .TIMEOUT_CYCLES(256)) u_main (
        .clk(clk), .rst_n(rst_n),
        .transaction_accepted(acc[0]), .inserted_programID(pid[0]),
        .collect_ready(cr[0]), .dispatch_valid(dv[0]), .dispatch_programID(did[0]),
        .dispatch_last(dl[0]), .dispatch_ready(rdy[0]), .batch_clear(bclr[0]),
        .batch_count(bcnt[0]), .drop_count(drop[0])
    );

    batch_dispatcher #(.ID_W(IDW), .BATCH_DEPTH(16), .TIMEOUT_CYCLES(8)) u_to (
        .clk(clk), .rst_n(rst_n),
        .transaction_accepted(acc[1]), .inserted_programID(pid[1]),
        .collect_ready(cr[1]), .dispatch_valid(dv[1]), .dispatch_programID(did[1]),
        .dispatch_last(dl[1]), .dispatch_ready(rdy[1]), .batch_clear(bclr[1]),
        .batch_count(bcnt[1]), .drop_count(drop[1])
    );

    typedef struct packed {
        logic [IDW-1:0] id;
        logic           last;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // Monitor: pops the scoreboard on every handshake, checks hold-under-stall
    // and the clear / collect_ready sequence that follows the last ID.
    logic [1:0]          stall, clr_pend, cr_pend, stall_last;
    logic [1:0][IDW-1:0] stall_id;
    exp_t                got;

    always @(negedge clk) begin
        if (!rst_n) begin
            stall    = '0;
            clr_pend = '0;
            cr_pend  = '0;
        end else begin
            for (int k = 0; k < 2; k++) begin
                if (cr_pend[k]) begin
                    chk("collect_ready after clear", 64'(cr[k]), 64'd1);
                    cr_pend[k] = 1'b0;
                end
                if (clr_pend[k]) begin
                    chk("batch_clear pulse", 64'(bclr[k]), 64'd1);
                    clr_pend[k] = 1'b0;
                    cr_pend[k]  = 1'b1;
                end else if (bclr[k]) begin
                    chk("spurious batch_clear", 64'(bclr[k]), 64'd0);
                end
                if (stall[k]) begin
                    chk("stall valid held", 64'(dv[k]), 64'd1);
                    chk("stall id held", did[k], stall_id[k]);
                    chk("stall last held", 64'(dl[k]), 64'(stall_last[k]));
                end
                if (dv[k] && rdy[k]) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL extra dispatch dut%0d: got id %0h, expected none", k, did[k]);
                    end else begin
                        got = exp_q.pop_front();
                        chk("dispatch id", did[k], got.id);
                        chk("dispatch last", 64'(dl[k]), 64'(got.last));
                        if (got.last) clr_pend[k] = 1'b1;
                    end
                end
                stall[k]      = dv[k] && !rdy[k];
                stall_id[k]   = did[k];
                stall_last[k] = dl[k];
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic accept(input int k, input logic [63:0] id);
        acc[k] = 1'b1;
        pid[k] = id;
        tick();
        acc[k] = 1'b0;
    endtask

    task automatic push(input logic [63:0] id, input logic last);
        exp_t e;
        e.id   = id;
        e.last = last;
        exp_q.push_back(e);
    endtask

    task automatic drain(input int k, input int bound);
        int n = 0;
        while ((exp_q.size() != 0 || dv[k] || bclr[k]) && n < bound) begin
            tick();
            n++;
        end
        if (n >= bound) begin
            checks++;
            errors++;
            $display("FAIL drain dut%0d: %0d entries left, expected 0", k, exp_q.size());
            exp_q.delete();
        end
        tick();
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int  n, dropped;
        bit  done;
        rst_n = 1'b0;
        acc = '0; pid = '0; rdy = '0;
        #12;
        chk("reset collect_ready", 64'(cr[0]), 64'd1);
        chk("reset dispatch_valid", 64'(dv[0]), 64'd0);
        chk("reset dispatch_last", 64'(dl[0]), 64'd0);
        chk("reset dispatch_id", did[0], 64'd0);
        chk("reset batch_clear", 64'(bclr[0]), 64'd0);
        chk("reset batch_count", 64'(bcnt[0]), 64'd0);
        chk("reset drop_count", 64'(drop[0]), 64'd0);
        rst_n = 1'b1;
        tick();

        // Full batch of 1..16 with ready high.
        rdy[0] = 1'b1;
        for (int i = 1; i <= 16; i++) push(64'(i), i == 16);
        for (int i = 1; i <= 15; i++) accept(0, 64'(i));
        chk("count before fill", 64'(bcnt[0]), 64'd15);
        chk("no early dispatch", 64'(dv[0]), 64'd0);
        accept(0, 64'd16);
        chk("valid after fill", 64'(dv[0]), 64'd1);
        chk("ready low in dispatch", 64'(cr[0]), 64'd0);
        chk("count at fill", 64'(bcnt[0]), 64'd16);
        drain(0, 100);
        chk("count after clear", 64'(bcnt[0]), 64'd0);

        // Backpressure with 3 drops in DISPATCH and 1 in CLEAR.
        rdy[0] = 1'b0;
        for (int i = 0; i < 16; i++) push(64'h100 + 64'(i), i == 15);
        for (int i = 0; i < 16; i++) accept(0, 64'h100 + 64'(i));
        n = 0; dropped = 0; done = 1'b0;
        while (!done && n < 200) begin
            rdy[0] = n[0];
            if (dropped < 3) begin
                acc[0] = 1'b1;
                pid[0] = 64'hDEAD0 + 64'(dropped);
                dropped++;
            end
            tick();
            acc[0] = 1'b0;
            n++;
            if (bclr[0]) begin
                acc[0] = 1'b1;
                pid[0] = 64'hBAD;
                tick();
                acc[0] = 1'b0;
                done = 1'b1;
            end
        end
        chk("clear reached", 64'(done), 64'd1);
        chk("drop_count", 64'(drop[0]), 64'd4);
        chk("ready after clear", 64'(cr[0]), 64'd1);
        drain(0, 50);

        // Partial batch after drops closes on the default timeout.
        rdy[0] = 1'b1;
        push(64'h55, 1'b0);
        push(64'h66, 1'b1);
        accept(0, 64'h55);
        accept(0, 64'h66);
        chk("partial count", 64'(bcnt[0]), 64'd2);
        drain(0, 400);

        // Timeout of 8: first write at timer 0 -> 1, closes when timer is 7.
        rdy[1] = 1'b1;
        push(64'hA, 1'b0);
        push(64'hB, 1'b1);
        accept(1, 64'hA);
        accept(1, 64'hB);
        chk("timeout count", 64'(bcnt[1]), 64'd2);
        repeat (5) tick();
        chk("no close before timeout", 64'(dv[1]), 64'd0);
        tick();
        chk("close at timeout", 64'(dv[1]), 64'd1);
        drain(1, 50);
        chk("timeout count cleared", 64'(bcnt[1]), 64'd0);

        // Accept on the timeout edge joins the batch as the last entry.
        push(64'h1, 1'b0);
        push(64'h2, 1'b1);
        accept(1, 64'h1);
        repeat (6) tick();
        chk("open before edge", 64'(dv[1]), 64'd0);
        accept(1, 64'h2);
        chk("simul close valid", 64'(dv[1]), 64'd1);
        chk("simul close count", 64'(bcnt[1]), 64'd2);
        drain(1, 50);

        // Async reset mid-dispatch.
        rdy[0] = 1'b1;
        for (int i = 0; i < 16; i++) push(64'h200 + 64'(i), i == 15);
        for (int i = 0; i < 16; i++) accept(0, 64'h200 + 64'(i));
        repeat (3) tick();
        #2 rst_n = 1'b0;
        #1;
        chk("async valid", 64'(dv[0]), 64'd0);
        chk("async clear", 64'(bclr[0]), 64'd0);
        chk("async ready", 64'(cr[0]), 64'd1);
        chk("async id", did[0], 64'd0);
        chk("async last", 64'(dl[0]), 64'd0);
        chk("async count", 64'(bcnt[0]), 64'd0);
        chk("async drops", 64'(drop[0]), 64'd0);
        exp_q.delete();
        tick();
        rst_n = 1'b1;
        tick();
        push(64'h77, 1'b0);
        push(64'h88, 1'b1);
        accept(0, 64'h77);
        accept(0, 64'h88);
        drain(0, 400);

        chk("scoreboard empty", 64'(exp_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/batch_dispatcher.md
# batch_dispatcher

Downstream stage of the scheduler pipeline, fed by the batch storage stage. Collects the stream of accepted program IDs into a conflict-free batch and closes the batch on size or timeout. Streams the closed batch to the executor interface over a valid/ready handshake, then pulses a clear so upstream stages can reset their batch filter state.

## Interface
Parameters:
- `ID_W`, 64, program ID width.
- `BATCH_DEPTH`, 16, maximum IDs per batch (power of two, ≥2).
- `TIMEOUT_CYCLES`, 256, cycles after the first ID of a batch before a partial batch is closed (≥2).

Ports (one clock; reset is asynchronous and active-low):
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous active-low reset.
- `transaction_accepted` in 1: one-cycle strobe, an ID was accepted by the batch stage.
- `inserted_programID` in ID_W: ID accompanying `transaction_accepted`.
- `collect_ready` out 1: high when an accept this cycle will be stored.
- `dispatch_valid` out 1: executor output valid.
- `dispatch_programID` out ID_W: ID being dispatched.
- `dispatch_last` out 1: marks the final ID of the batch.
- `dispatch_ready` in 1: executor accepts the current ID.
- `batch_clear` out 1: one-cycle pulse after a batch is fully dispatched.
- `batch_count` out log2(BATCH_DEPTH)+1: IDs currently held.
- `drop_count` out 16: saturating count of accepts that arrived while `collect_ready` was low.

## Operation
State machine:
- **COLLECT**
  - `collect_ready` = (`batch_count` < BATCH_DEPTH).
  - Accept with `collect_ready` high: write `buf[batch_count]`, then increment `batch_count`.
  - Accept with `collect_ready` low: discard the ID and increment `drop_count`, saturating at 0xFFFF.
- **COLLECT → DISPATCH** at the edge where either:
  - the post-update count equals BATCH_DEPTH, or
  - the timer equals TIMEOUT_CYCLES−1 and the post-update count is >0.
- **Timer**
  - Held at 0 while `batch_count`==0.
  - Increments every cycle while in COLLECT with `batch_count`>0, including the cycle of the first write.
  - Cleared on leaving COLLECT.
- **DISPATCH**
  - `collect_ready`=0 and `dispatch_valid`=1.
  - `dispatch_programID`=`buf[rd_ptr]`.
  - `dispatch_last`=(`rd_ptr`==`batch_count`−1).
  - Handshake (`dispatch_valid`&&`dispatch_ready`): `rd_ptr` increments.
  - Handshake with `dispatch_last`=1 → CLEAR.
  - Accepts arriving in DISPATCH are dropped and counted.
- **CLEAR** (exactly one cycle)
  - `batch_clear`=1 and `collect_ready`=0; accepts are dropped and counted.
  - Next edge: `batch_count`=0, `rd_ptr`=0, state → COLLECT.
- **Output stability:** while `dispatch_valid`=1 and `dispatch_ready`=0, `dispatch_programID` and `dispatch_last` hold stable.
- **Empty batches:** never dispatched.

## Timing
- Reset values: state=COLLECT, `batch_count`=0, `rd_ptr`=0, timer=0, `drop_count`=0, `collect_ready`=1, `dispatch_valid`=0, `dispatch_last`=0, `dispatch_programID`=0, `batch_clear`=0.
- Accept-to-storage: `batch_count` and the buffer update at the edge that samples the strobe.
- Close-to-dispatch: `dispatch_valid` rises the cycle after the closing edge; all outputs are decoded from registered state.
- Throughput: one ID per cycle with `dispatch_ready` held high; a batch of N takes N dispatch cycles plus 1 CLEAR cycle.
- Simultaneous events:
  - Accept and timeout in the same cycle: the ID is stored, then the batch closes.
  - Accept that fills the last slot: stored, then the batch closes.
- Reset mid-operation: all state is abandoned immediately; `dispatch_valid` and `batch_clear` drop asynchronously and no partial batch is resumed.

## Structure
- `sched_pkg` holds:
  - `ID_W` default constant;
  - `disp_state_t` enum (COLLECT, DISPATCH, CLEAR);
  - `CNT_W` = $clog2(BATCH_DEPTH)+1 helper.
- Sub-module `id_buffer`: BATCH_DEPTH×ID_W register array with one write port (index, data, enable) and one combinational read port (index).
- FSM, counters and timer live in `batch_dispatcher`.

## Test plan
- **Full batch:** reset, then 16 consecutive accepts of IDs 1..16 with `dispatch_ready`=1 → `dispatch_valid` the cycle after the 16th accept; IDs 1..16 in order; `dispatch_last` only on 16; `batch_clear` one cycle after; `collect_ready` back high the following cycle.
- **Timeout:** TIMEOUT_CYCLES=8, accept IDs 0xA, 0xB on cycles 0 and 1, then idle → close at timer 7, dispatch 0xA then 0xB (`last`), `batch_count` returns to 0.
- **Backpressure:** during dispatch, toggle `dispatch_ready` 0/1 every cycle → each ID held stable while `ready`=0, no duplicates or skips, 16 handshakes total.
- **Drops:** 3 accepts during DISPATCH plus 1 in CLEAR → `drop_count`=4, and the buffer contents of the next batch are unaffected.
- **Simultaneous close:** accept on the same cycle the timer hits TIMEOUT_CYCLES−1 → the ID is included as the last dispatched entry.
- **Async reset:** assert `rst_n` low mid-dispatch → all outputs at reset values without a clock edge; after release, a fresh batch of 2 IDs dispatches correctly.
